// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter: FSM state encoding,
// oversampling constants, mid-bit sample indices, data width, divisor type and
// the baud divisor helper.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;

  // Tick indices inside a 16-tick bit window used for the 3-sample vote.
  localparam logic [3:0] SAMPLE_LO  = 4'd7;
  localparam logic [3:0] SAMPLE_MID = 4'd8;
  localparam logic [3:0] SAMPLE_HI  = 4'd9;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  typedef logic [31:0] uart_div_t;

  // clk_freq / (baud * os) in 32-bit arithmetic; a zero result (or a zero
  // denominator) yields 1 so the tick counter always advances.
  function automatic uart_div_t calc_div(input uart_div_t freq,
                                         input uart_div_t rate,
                                         input int unsigned os);
    uart_div_t den;
    uart_div_t q;
    den = rate * uart_div_t'(os);
    if (den == '0) begin
      q = '0;
    end else begin
      q = freq / den;
    end
    if (q == '0) begin
      q = 32'd1;
    end
    return q;
  endfunction

  // 2-of-3 majority.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Oversampling tick generator. Computes the divisor every cycle from the
// clock frequency and baud rate, latches it when a frame starts, and pulses
// tick once every div clocks while enabled.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   clk_freq, baud  clock frequency (Hz) and baud rate (bit/s)
//   restart         latch divisor and zero the counter (frame start)
//   enable          count while high
//   tick            one-cycle pulse when the counter wraps
// -----------------------------------------------------------------------------
module uart_baud_tick #(
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clk_freq,
  input  logic [31:0] baud,
  input  logic        restart,
  input  logic        enable,
  output logic        tick
);
  import uart_pkg::*;

  uart_div_t tick_div_q, tick_div_d;
  uart_div_t div_q, div_d;
  uart_div_t cnt_q, cnt_d;
  logic      wrap;

  // Counter has reached the last count of the latched period.
  assign wrap = (cnt_q >= (div_q - 32'd1));
  assign tick = enable && !restart && wrap;

  always_comb begin
    tick_div_d = calc_div(clk_freq, baud, OVERSAMPLE);
    div_d      = div_q;
    cnt_d      = cnt_q;
    if (restart) begin
      // Divisor is frozen for the whole frame; counter phase-aligns to the edge.
      div_d = tick_div_q;
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_div_q <= 32'd1;
      div_q      <= 32'd1;
      cnt_q      <= '0;
    end else begin
      tick_div_q <= tick_div_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// -----------------------------------------------------------------------------
// uart_rx_os
// 8N1 UART receiver with 16x oversampling and runtime baud programming.
// Synchronizes rx, rejects start glitches, majority-votes each bit on ticks
// 7/8/9 and hands bytes out through a valid/ready handshake.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   clk_freq, baud     clock frequency (Hz), baud rate (bit/s)
//   rx                 asynchronous serial input, idle high
//   rx_ready           consumer accepts data_out while rx_valid is high
//   data_out           last received byte (LSB received first)
//   rx_valid           byte available, held until accepted
//   frame_err          1-cycle pulse: stop bit sampled 0
//   overrun            1-cycle pulse: byte completed while rx_valid still high
//   busy               frame in progress
// -----------------------------------------------------------------------------
module uart_rx_os #(
  parameter int OVERSAMPLE  = uart_pkg::OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] clk_freq,
  input  logic [31:0] baud,
  input  logic        rx,
  input  logic        rx_ready,
  output logic [7:0]  data_out,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy
);
  import uart_pkg::*;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  uart_state_e            state_q, state_d;
  logic [3:0]             t_q, t_d;
  logic [2:0]             bit_q, bit_d;
  logic                   s0_q, s0_d;
  logic                   s1_q, s1_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   armed_q, armed_d;

  logic rx_s;
  logic restart;
  logic tick;
  logic vote;

  assign rx_s    = sync_q[SYNC_STAGES-1];
  assign restart = (state_q == IDLE) && armed_q && !rx_s;
  // The third sample is taken live on the t=9 tick.
  assign vote    = maj3(s0_q, s1_q, rx_s);

  assign data_out  = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != IDLE);

  uart_baud_tick #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clk_freq (clk_freq),
    .baud     (baud),
    .restart  (restart),
    .enable   (busy),
    .tick     (tick)
  );

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], rx};
    state_d = state_q;
    t_d     = t_q;
    bit_d   = bit_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    armed_d = armed_q;

    // Sample capture is common to every active state.
    if (busy && tick) begin
      if (t_q == SAMPLE_LO)  s0_d = rx_s;
      if (t_q == SAMPLE_MID) s1_d = rx_s;
      t_d = t_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (rx_s) armed_d = 1'b1;
        if (restart) begin
          state_d = START;
          t_d     = '0;
        end
      end
      START: begin
        if (tick) begin
          if (t_q == SAMPLE_HI && vote) begin
            state_d = IDLE;           // glitch: silently back to idle
          end else if (t_q == TICK_LAST) begin
            // Start confirmed at t=9; the start window runs out its 16 ticks
            // so every data window stays centred on the vote point.
            state_d = DATA;
            bit_d   = '0;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (t_q == SAMPLE_HI) shift_d = {vote, shift_q[7:1]};
          if (t_q == TICK_LAST) begin
            if (bit_q == BIT_LAST) state_d = STOP;
            else bit_d = bit_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (tick && t_q == SAMPLE_HI) begin
          state_d = IDLE;
          if (vote) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            // Acceptance in the same cycle means the old byte was consumed.
            ovr_d   = valid_q && !rx_ready;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;           // wait for the line to return high
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '1;
      state_q <= IDLE;
      t_q     <= '0;
      bit_q   <= '0;
      s0_q    <= 1'b1;
      s1_q    <= 1'b1;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      t_q     <= t_d;
      bit_q   <= bit_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os
// Directed self-checking bench for uart_rx_os at 50 MHz / 115200 baud
// (divisor 27, 432 clocks per bit).
// -----------------------------------------------------------------------------
module tb_uart_rx_os;

  localparam int BIT_CLKS  = 432;
  localparam int SLOW_CLKS = 445;   // bit period stretched by 3%

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] clk_freq;
  logic [31:0] baud;
  logic        rx;
  logic        rx_ready;
  logic [7:0]  data_out;
  logic        rx_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_rx_os #(
    .OVERSAMPLE  (16),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clk_freq  (clk_freq),
    .baud      (baud),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .data_out  (data_out),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  // Event counters sampled on the falling edge.
  int   valid_rises = 0;
  int   busy_rises  = 0;
  int   ferr_pulses = 0;
  int   ferr_long   = 0;
  int   ovr_pulses  = 0;
  int   ovr_long    = 0;
  logic prev_valid  = 1'b0;
  logic prev_busy   = 1'b0;
  logic prev_ferr   = 1'b0;
  logic prev_ovr    = 1'b0;

  always @(negedge clk) begin
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) valid_rises <= valid_rises + 1;
    if (busy === 1'b1 && prev_busy !== 1'b1) busy_rises <= busy_rises + 1;
    if (frame_err === 1'b1) ferr_pulses <= ferr_pulses + 1;
    if (frame_err === 1'b1 && prev_ferr === 1'b1) ferr_long <= ferr_long + 1;
    if (overrun === 1'b1) ovr_pulses <= ovr_pulses + 1;
    if (overrun === 1'b1 && prev_ovr === 1'b1) ovr_long <= ovr_long + 1;
    prev_valid <= rx_valid;
    prev_busy  <= busy;
    prev_ferr  <= frame_err;
    prev_ovr   <= overrun;
  end

  // Drive one 10-bit frame from a falling edge; bit index 0 is the start bit.
  // noise_idx inverts clocks 203..229 of that bit; check_lat verifies the
  // 3-clock start detection latency.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int bit_clks, input int noise_idx,
                            input bit check_lat);
    logic [9:0] frame;
    logic       flip;
    frame = {stop_bit, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < bit_clks; c++) begin
        flip = (i == noise_idx) && (c >= 203) && (c < 230);
        rx = frame[i] ^ flip;
        @(negedge clk);
        if (check_lat && i == 0 && c == 1) begin
          checks++;
          if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_latency_early busy=%b expected 0", busy);
          end
        end
        if (check_lat && i == 0 && c == 2) begin
          checks++;
          if (busy !== 1'b1) begin
            errors++;
            $display("FAIL start_latency busy=%b expected 1", busy);
          end
        end
      end
    end
    rx = 1'b1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    rx_ready = 1'b0;
    clk_freq = 32'd50_000_000;
    baud = 32'd115_200;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs data=%h valid=%b ferr=%b ovr=%b busy=%b expected all 0",
               data_out, rx_valid, frame_err, overrun, busy);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle busy=%b valid=%b expected 0 0", busy, rx_valid);
    end
    $display("reset: outputs checked");
  endtask

  task automatic test_clean_byte();
    int v0, f0, o0;
    rx_ready = 1'b1;
    v0 = valid_rises; f0 = ferr_pulses; o0 = ovr_pulses;
    send_frame(8'hA5, 1'b1, BIT_CLKS, -1, 1'b1);
    idle(4);
    checks++;
    if (data_out !== 8'hA5) begin
      errors++;
      $display("FAIL clean_data got %h expected a5", data_out);
    end
    checks++;
    if (valid_rises - v0 !== 1) begin
      errors++;
      $display("FAIL clean_valid_count got %0d expected 1", valid_rises - v0);
    end
    checks++;
    if (ferr_pulses - f0 !== 0 || ovr_pulses - o0 !== 0) begin
      errors++;
      $display("FAIL clean_flags ferr=%0d ovr=%0d expected 0 0", ferr_pulses - f0, ovr_pulses - o0);
    end
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL clean_accepted valid=%b expected 0", rx_valid);
    end
    $display("clean byte: data_out=%h", data_out);
  endtask

  task automatic test_glitch();
    int v0, f0, b0;
    v0 = valid_rises; f0 = ferr_pulses; b0 = busy_rises;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    idle(600);
    checks++;
    if (busy_rises - b0 !== 1) begin
      errors++;
      $display("FAIL glitch_busy_rise got %0d expected 1", busy_rises - b0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL glitch_busy_drop busy=%b expected 0", busy);
    end
    checks++;
    if (valid_rises - v0 !== 0 || ferr_pulses - f0 !== 0) begin
      errors++;
      $display("FAIL glitch_no_event valid=%0d ferr=%0d expected 0 0", valid_rises - v0, ferr_pulses - f0);
    end
    $display("glitch: busy_rises=%0d", busy_rises - b0);
  endtask

  task automatic test_frame_err();
    int v0, f0, fl0;
    v0 = valid_rises; f0 = ferr_pulses; fl0 = ferr_long;
    send_frame(8'h3C, 1'b0, BIT_CLKS, -1, 1'b0);
    rx = 1'b0;
    repeat (2 * BIT_CLKS) @(negedge clk);
    checks++;
    if (ferr_pulses - f0 !== 1 || ferr_long - fl0 !== 0) begin
      errors++;
      $display("FAIL ferr_pulse cycles=%0d long=%0d expected 1 0", ferr_pulses - f0, ferr_long - fl0);
    end
    checks++;
    if (data_out !== 8'hA5 || valid_rises - v0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ferr_hold data=%h valid_rises=%0d busy=%b expected a5 0 0",
               data_out, valid_rises - v0, busy);
    end
    idle(2 * BIT_CLKS);
    send_frame(8'h55, 1'b1, BIT_CLKS, -1, 1'b0);
    idle(4);
    checks++;
    if (data_out !== 8'h55 || valid_rises - v0 !== 1) begin
      errors++;
      $display("FAIL ferr_recover data=%h valid_rises=%0d expected 55 1", data_out, valid_rises - v0);
    end
    $display("frame error: pulses=%0d then data_out=%h", ferr_pulses - f0, data_out);
  endtask

  task automatic test_overrun();
    int o0, ol0;
    o0 = ovr_pulses; ol0 = ovr_long;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, BIT_CLKS, -1, 1'b0);
    checks++;
    if (data_out !== 8'h11 || rx_valid !== 1'b1 || ovr_pulses - o0 !== 0) begin
      errors++;
      $display("FAIL overrun_first data=%h valid=%b ovr=%0d expected 11 1 0",
               data_out, rx_valid, ovr_pulses - o0);
    end
    send_frame(8'h22, 1'b1, BIT_CLKS, -1, 1'b0);
    checks++;
    if (ovr_pulses - o0 !== 1 || ovr_long - ol0 !== 0) begin
      errors++;
      $display("FAIL overrun_pulse cycles=%0d long=%0d expected 1 0", ovr_pulses - o0, ovr_long - ol0);
    end
    checks++;
    if (data_out !== 8'h22 || rx_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_data data=%h valid=%b expected 22 1", data_out, rx_valid);
    end
    rx_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_accept valid=%b expected 0", rx_valid);
    end
    $display("overrun: pulses=%0d data_out=%h", ovr_pulses - o0, data_out);
  endtask

  task automatic test_noise_baud();
    int v0;
    v0 = valid_rises;
    send_frame(8'hF0, 1'b1, BIT_CLKS, 4, 1'b0);
    idle(4);
    checks++;
    if (data_out !== 8'hF0 || valid_rises - v0 !== 1) begin
      errors++;
      $display("FAIL noise_nominal data=%h valid_rises=%0d expected f0 1", data_out, valid_rises - v0);
    end
    idle(BIT_CLKS);
    v0 = valid_rises;
    send_frame(8'h0F, 1'b1, BIT_CLKS, -1, 1'b0);
    send_frame(8'hF0, 1'b1, SLOW_CLKS, 4, 1'b0);
    idle(4);
    checks++;
    if (data_out !== 8'hF0 || valid_rises - v0 !== 2) begin
      errors++;
      $display("FAIL noise_slow data=%h valid_rises=%0d expected f0 2", data_out, valid_rises - v0);
    end
    $display("noise/baud offset: data_out=%h", data_out);
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0, o0;
    logic [9:0] frame;
    rx_ready = 1'b1;
    frame = {1'b1, 8'h99, 1'b0};
    for (int i = 0; i < 5; i++) begin
      rx = frame[i];
      repeat ((i == 4) ? BIT_CLKS / 2 : BIT_CLKS) @(negedge clk);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy busy=%b expected 1", busy);
    end
    v0 = valid_rises; f0 = ferr_pulses; o0 = ovr_pulses;
    rst = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_out, rx_valid, frame_err, overrun, busy} !== 12'h000) begin
      errors++;
      $display("FAIL midframe_reset data=%h valid=%b ferr=%b ovr=%b busy=%b expected all 0",
               data_out, rx_valid, frame_err, overrun, busy);
    end
    repeat (4) @(negedge clk);
    rst = 1'b0;
    idle(2 * BIT_CLKS);
    checks++;
    if (valid_rises - v0 !== 0 || ferr_pulses - f0 !== 0 || ovr_pulses - o0 !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midframe_silent valid=%0d ferr=%0d ovr=%0d busy=%b expected 0 0 0 0",
               valid_rises - v0, ferr_pulses - f0, ovr_pulses - o0, busy);
    end
    send_frame(8'h42, 1'b1, BIT_CLKS, -1, 1'b0);
    idle(4);
    checks++;
    if (data_out !== 8'h42 || valid_rises - v0 !== 1) begin
      errors++;
      $display("FAIL midframe_resume data=%h valid_rises=%0d expected 42 1", data_out, valid_rises - v0);
    end
    $display("reset mid-frame: data_out=%h", data_out);
  endtask

  initial begin
    test_reset();
    test_clean_byte();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_noise_baud();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
